// File: rtl/threshold_monitor_pkg.sv
`default_nettype none
// ==== threshold_monitor_pkg : shared types and constants for threshold_monitor  (rev 1.0) ====
package threshold_monitor_pkg;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      PEND_HI = 2'd1,
      ALARM   = 2'd2,
      PEND_LO = 2'd3
   } state_t;

   localparam int C_ST_ALARM    = 31;
   localparam int C_ST_STICKY   = 30;
   localparam int C_ST_STATE_HI = 29;
   localparam int C_ST_STATE_LO = 28;
   localparam int C_ST_CNT_LO   = 16;

   localparam int C_CNT_FIELD_W = 12;
   localparam int C_DB_WIDTH    = 4;

   localparam logic [15:0] C_HI_THR_RESET = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/threshold_event_counter.sv
`default_nettype none
// ==== threshold_event_counter : saturating event counter, increment beats clear  (rev 1.0) ====
module threshold_event_counter #(
   parameter int G_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               incr,
   output logic [G_WIDTH-1:0] count
);

   localparam logic [G_WIDTH-1:0] C_MAX = '1;

   // A clear coinciding with an event restarts the count at one rather than zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (incr && clear) begin
         count <= G_WIDTH'(1);
      end else if (incr) begin
         if (count != C_MAX) begin
            count <= count + G_WIDTH'(1);
         end
      end else if (clear) begin
         count <= '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/threshold_monitor.sv
`default_nettype none
// ==== threshold_monitor : debounced, hysteretic threshold alarm over a sample stream  (rev 1.0) ====
module threshold_monitor
   import threshold_monitor_pkg::*;
#(
   parameter int G_DEBOUNCE  = 4,
   parameter int G_CNT_WIDTH = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] thresholds_i,
   input  logic        thr_hi_we_i,
   input  logic [15:0] sample_i,
   input  logic        sample_valid_i,
   input  logic        clear_i,
   output logic        alarm_o,
   output logic        alarm_rise_o,
   output logic [31:0] status_o
);

   localparam logic [C_DB_WIDTH-1:0] C_DB_TARGET = C_DB_WIDTH'(G_DEBOUNCE);
   localparam logic [C_DB_WIDTH-1:0] C_DB_ONE    = C_DB_WIDTH'(1);

   state_t                  state;
   logic [C_DB_WIDTH-1:0]   db_cnt;
   logic [C_DB_WIDTH-1:0]   db_next;
   logic [15:0]             hi_thr;
   logic [15:0]             lo_thr;
   logic [15:0]             last_sample;
   logic                    sticky;
   logic                    above_hi;
   logic                    below_lo;
   logic                    enter_alarm;
   logic [G_CNT_WIDTH-1:0]  event_cnt;

   assign lo_thr   = thresholds_i[15:0];
   assign above_hi = sample_i > hi_thr;
   assign below_lo = sample_i < lo_thr;
   assign db_next  = db_cnt + C_DB_ONE;

   always_comb begin
      enter_alarm = 1'b0;
      if (sample_valid_i && above_hi) begin
         if (state == NORMAL)
            enter_alarm = (C_DB_TARGET == C_DB_ONE);
         else if (state == PEND_HI)
            enter_alarm = (db_next == C_DB_TARGET);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= NORMAL;
         db_cnt       <= '0;
         alarm_o      <= 1'b0;
         alarm_rise_o <= 1'b0;
      end else begin
         alarm_rise_o <= enter_alarm;
         if (sample_valid_i) begin
            case (state)
               NORMAL: begin
                  if (above_hi) begin
                     if (C_DB_TARGET == C_DB_ONE) begin
                        state   <= ALARM;
                        alarm_o <= 1'b1;
                     end else begin
                        state  <= PEND_HI;
                        db_cnt <= C_DB_ONE;
                     end
                  end
               end
               PEND_HI: begin
                  if (above_hi) begin
                     if (db_next == C_DB_TARGET) begin
                        state   <= ALARM;
                        db_cnt  <= '0;
                        alarm_o <= 1'b1;
                     end else begin
                        db_cnt <= db_next;
                     end
                  end else begin
                     state  <= NORMAL;
                     db_cnt <= '0;
                  end
               end
               ALARM: begin
                  if (below_lo) begin
                     if (C_DB_TARGET == C_DB_ONE) begin
                        state   <= NORMAL;
                        alarm_o <= 1'b0;
                     end else begin
                        state  <= PEND_LO;
                        db_cnt <= C_DB_ONE;
                     end
                  end
               end
               PEND_LO: begin
                  if (below_lo) begin
                     if (db_next == C_DB_TARGET) begin
                        state   <= NORMAL;
                        db_cnt  <= '0;
                        alarm_o <= 1'b0;
                     end else begin
                        db_cnt <= db_next;
                     end
                  end else begin
                     state  <= ALARM;
                     db_cnt <= '0;
                  end
               end
               default: begin
                  state  <= NORMAL;
                  db_cnt <= '0;
               end
            endcase
         end
      end
   end

   // High threshold is only meaningful on the bus during the write strobe, so hold a copy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hi_thr      <= C_HI_THR_RESET;
         sticky      <= 1'b0;
         last_sample <= '0;
      end else begin
         if (thr_hi_we_i)
            hi_thr <= thresholds_i[31:16];
         if (enter_alarm)
            sticky <= 1'b1;
         else if (clear_i)
            sticky <= 1'b0;
         if (sample_valid_i)
            last_sample <= sample_i;
      end
   end

   threshold_event_counter #(
      .G_WIDTH (G_CNT_WIDTH)
   ) u_event_counter (
      .clk   (clk_i),
      .rst   (rst_i),
      .clear (clear_i),
      .incr  (enter_alarm),
      .count (event_cnt)
   );

   assign status_o[C_ST_ALARM]                      = alarm_o;
   assign status_o[C_ST_STICKY]                     = sticky;
   assign status_o[C_ST_STATE_HI:C_ST_STATE_LO]     = state;
   assign status_o[C_ST_STATE_LO-1:C_ST_CNT_LO]     = C_CNT_FIELD_W'(event_cnt);
   assign status_o[C_ST_CNT_LO-1:0]                 = last_sample;

endmodule
`default_nettype wire
